// File: rtl/seg_scan_mux_if.sv
// Bus between display-data producers (master) and the seg_scan_mux scanner (slave).
// Groups the data-capture strobe, per-digit data bank and the scanned pin outputs.
interface seg_scan_mux_if #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned BRT_W  = 4
);
  localparam int unsigned SCAN_W = $clog2(DIGITS);

  logic                  load;
  logic [4*DIGITS-1:0]   hexs;
  logic [DIGITS-1:0]     points;
  logic [DIGITS-1:0]     LEs;
  logic [DIGITS-1:0]     digit_en;
  logic [DIGITS-1:0]     blink_mask;
  logic [BRT_W-1:0]      brightness;

  logic [3:0]            HEX;
  logic [DIGITS-1:0]     AN;
  logic                  point;
  logic                  LE;
  logic [SCAN_W-1:0]     scan;
  logic                  frame_start;

  modport master (
    output load, hexs, points, LEs, digit_en, blink_mask, brightness,
    input  HEX, AN, point, LE, scan, frame_start
  );

  modport slave (
    input  load, hexs, points, LEs, digit_en, blink_mask, brightness,
    output HEX, AN, point, LE, scan, frame_start
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Self-timed common-anode seven-segment scanner with shadow-buffered data, PWM brightness
// and per-digit enable. Optional blink logic is built when SEG_BLINK_EN is defined.
module seg_scan_mux #(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned DWELL_LOG2   = 16,
  parameter int unsigned BRT_W        = 4,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic          clk,
  input  logic          rst,
  seg_scan_mux_if.slave bus
);

  localparam int unsigned SCAN_W = $clog2(DIGITS);
  localparam int unsigned HEX_W  = 4 * DIGITS;

  logic [DWELL_LOG2-1:0] dwell_q, dwell_d;
  logic [SCAN_W-1:0]     scan_q, scan_d;
  logic                  wrap_q, wrap_d;
  logic                  dwell_end_c;
  logic                  boundary_c;
  logic                  pwm_on_c;
  logic [DIGITS-1:0]     blank_c;

  logic [HEX_W-1:0]      hex_pend_q, hex_pend_d, hex_act_q, hex_act_d;
  logic [DIGITS-1:0]     pt_pend_q, pt_pend_d, pt_act_q, pt_act_d;
  logic [DIGITS-1:0]     le_pend_q, le_pend_d, le_act_q, le_act_d;
  logic [DIGITS-1:0]     en_pend_q, en_pend_d, en_act_q, en_act_d;
  logic [BRT_W-1:0]      brt_pend_q, brt_pend_d, brt_act_q, brt_act_d;

  logic [3:0]            hex_out_q, hex_out_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  point_q, point_d;
  logic                  le_q, le_d;
  logic [SCAN_W-1:0]     scan_out_q, scan_out_d;
  logic                  fs_q, fs_d;

  assign dwell_end_c = &dwell_q;
  assign boundary_c  = dwell_end_c && (scan_q == SCAN_W'(DIGITS - 1));
  assign pwm_on_c    = dwell_q[DWELL_LOG2-1 -: BRT_W] <= brt_act_q;

  // Dwell timer and digit scan; wrap_q marks the first cycle of a new frame.
  always_comb begin
    dwell_d = dwell_q + DWELL_LOG2'(1);
    scan_d  = scan_q;
    wrap_d  = boundary_c;
    if (dwell_end_c) begin
      scan_d = boundary_c ? '0 : scan_q + SCAN_W'(1);
    end
  end

  // Pending bank tracks every load; active bank only swaps at the frame boundary.
  always_comb begin
    hex_pend_d = hex_pend_q;
    pt_pend_d  = pt_pend_q;
    le_pend_d  = le_pend_q;
    en_pend_d  = en_pend_q;
    brt_pend_d = brt_pend_q;
    hex_act_d  = hex_act_q;
    pt_act_d   = pt_act_q;
    le_act_d   = le_act_q;
    en_act_d   = en_act_q;
    brt_act_d  = brt_act_q;
    if (bus.load) begin
      hex_pend_d = bus.hexs;
      pt_pend_d  = bus.points;
      le_pend_d  = bus.LEs;
      en_pend_d  = bus.digit_en;
      brt_pend_d = bus.brightness;
    end
    if (boundary_c) begin
      if (bus.load) begin
        hex_act_d = bus.hexs;
        pt_act_d  = bus.points;
        le_act_d  = bus.LEs;
        en_act_d  = bus.digit_en;
        brt_act_d = bus.brightness;
      end else begin
        hex_act_d = hex_pend_q;
        pt_act_d  = pt_pend_q;
        le_act_d  = le_pend_q;
        en_act_d  = en_pend_q;
        brt_act_d = brt_pend_q;
      end
    end
  end

  // Select the scanned digit's active values; only the anode depends on lit.
  always_comb begin
    logic lit;
    lit        = 1'b0;
    hex_out_d  = '0;
    point_d    = 1'b0;
    le_d       = 1'b0;
    an_d       = '1;
    scan_out_d = scan_q;
    fs_d       = wrap_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scan_q == SCAN_W'(i)) begin
        hex_out_d = 4'(hex_act_q >> (4 * i));
        point_d   = 1'(pt_act_q >> i);
        le_d      = 1'(le_act_q >> i);
        lit       = 1'(en_act_q >> i) & ~1'(blank_c >> i) & pwm_on_c;
        an_d      = ~(DIGITS'(lit) << i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q    <= '0;
      scan_q     <= '0;
      wrap_q     <= 1'b0;
      hex_pend_q <= '0;
      pt_pend_q  <= '0;
      le_pend_q  <= '0;
      en_pend_q  <= '0;
      brt_pend_q <= '0;
      hex_act_q  <= '0;
      pt_act_q   <= '0;
      le_act_q   <= '0;
      en_act_q   <= '0;
      brt_act_q  <= '0;
      hex_out_q  <= '0;
      an_q       <= '1;
      point_q    <= 1'b0;
      le_q       <= 1'b0;
      scan_out_q <= '0;
      fs_q       <= 1'b0;
    end else begin
      dwell_q    <= dwell_d;
      scan_q     <= scan_d;
      wrap_q     <= wrap_d;
      hex_pend_q <= hex_pend_d;
      pt_pend_q  <= pt_pend_d;
      le_pend_q  <= le_pend_d;
      en_pend_q  <= en_pend_d;
      brt_pend_q <= brt_pend_d;
      hex_act_q  <= hex_act_d;
      pt_act_q   <= pt_act_d;
      le_act_q   <= le_act_d;
      en_act_q   <= en_act_d;
      brt_act_q  <= brt_act_d;
      hex_out_q  <= hex_out_d;
      an_q       <= an_d;
      point_q    <= point_d;
      le_q       <= le_d;
      scan_out_q <= scan_out_d;
      fs_q       <= fs_d;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic              phase_q, phase_d;
  logic [DIGITS-1:0] mask_pend_q, mask_pend_d, mask_act_q, mask_act_d;

  // Blink mask follows the same shadow path; phase toggles every BLINK_FRAMES frames.
  always_comb begin
    fcnt_d      = fcnt_q;
    phase_d     = phase_q;
    mask_pend_d = bus.load ? bus.blink_mask : mask_pend_q;
    mask_act_d  = mask_act_q;
    if (boundary_c) begin
      mask_act_d = bus.load ? bus.blink_mask : mask_pend_q;
      if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q      <= '0;
      phase_q     <= 1'b0;
      mask_pend_q <= '0;
      mask_act_q  <= '0;
    end else begin
      fcnt_q      <= fcnt_d;
      phase_q     <= phase_d;
      mask_pend_q <= mask_pend_d;
      mask_act_q  <= mask_act_d;
    end
  end

  assign blank_c = phase_q ? mask_act_q : '0;
`else
  logic [DIGITS:0] unused_blink;
  assign unused_blink = {bus.blink_mask, BLINK_FRAMES[0]};
  assign blank_c      = '0;
`endif

  assign bus.HEX         = hex_out_q;
  assign bus.AN          = an_q;
  assign bus.point       = point_q;
  assign bus.LE          = le_q;
  assign bus.scan        = scan_out_q;
  assign bus.frame_start = fs_q;

endmodule
